// File: rtl/swap_register_file_if.sv
// Host-side bundle for swap_register_file: write port, combinational read port and
// the swap command handshake, grouped so checkers can bind to one place.
interface swap_register_file_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              we;
  logic [ADDR_W-1:0] address_w;
  logic [DATA_W-1:0] data_w;
  logic [ADDR_W-1:0] address_r;
  logic [DATA_W-1:0] data_r;
  logic              swap_start;
  logic [ADDR_W-1:0] swap_addr_a;
  logic [ADDR_W-1:0] swap_addr_b;
  logic              swap_busy;
  logic              swap_done;
  logic              wr_rejected;
  logic [CNT_W-1:0]  swap_count;

  // Handshake: swap_start is accepted only on an edge where swap_busy is low; once
  // accepted, swap_busy stays high for exactly three cycles, then swap_done pulses
  // once. A start seen while busy is dropped, never queued. A write seen while busy
  // is dropped and flagged by a one-cycle wr_rejected pulse on the following cycle.
  modport master (
    output we, address_w, data_w, address_r, swap_start, swap_addr_a, swap_addr_b,
    input  data_r, swap_busy, swap_done, wr_rejected, swap_count
  );

  modport slave (
    input  we, address_w, data_w, address_r, swap_start, swap_addr_a, swap_addr_b,
    output data_r, swap_busy, swap_done, wr_rejected, swap_count
  );
endinterface

// File: rtl/swap_register_file.sv
// Register file with one write port, one combinational read port and a swap engine
// that exchanges two entries while locking out the external write port.
module swap_register_file #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  swap_register_file_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WR_A = 2'd2,
    WR_B = 2'd3
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] tmp_a_q, tmp_a_d;
  logic [DATA_W-1:0] tmp_b_q, tmp_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rej_q, rej_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    tmp_a_d   = tmp_a_q;
    tmp_b_d   = tmp_b_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rej_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.address_w;
    mem_wdata = bus.data_w;

    case (state_q)
      IDLE: begin
        // A write in the start cycle commits first, so LOAD sees the new value.
        mem_we = bus.we;
        if (bus.swap_start) begin
          addr_a_d = bus.swap_addr_a;
          addr_b_d = bus.swap_addr_b;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        tmp_a_d = mem_q[addr_a_q];
        tmp_b_d = mem_q[addr_b_q];
        state_d = WR_A;
      end
      WR_A: begin
        mem_we    = 1'b1;
        mem_waddr = addr_a_q;
        mem_wdata = tmp_b_q;
        state_d   = WR_B;
      end
      WR_B: begin
        mem_we    = 1'b1;
        mem_waddr = addr_b_q;
        mem_wdata = tmp_a_q;
        done_d    = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && bus.we) rej_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q  <= IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tmp_a_q  <= '0;
      tmp_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tmp_a_q  <= tmp_a_d;
      tmp_b_q  <= tmp_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rej_q    <= rej_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.data_r      = mem_q[bus.address_r];
  assign bus.swap_busy   = busy_q;
  assign bus.swap_done   = done_q;
  assign bus.wr_rejected = rej_q;
  assign bus.swap_count  = cnt_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_swap_register_file.sv
// Directed bench for swap_register_file: a reference memory model feeds an expected
// queue on each stimulus step, and DUT outputs are popped against it.
module tb_swap_register_file;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  always #5 clk = ~clk;

  swap_register_file_if #(.ADDR_W(7), .DATA_W(8), .CNT_W(16)) bus ();
  swap_register_file_if #(.ADDR_W(7), .DATA_W(8), .CNT_W(2))  bus2 ();

  swap_register_file #(.ADDR_W(7), .DATA_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  swap_register_file #(.ADDR_W(7), .DATA_W(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .dbg_state(dbg_state2)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  model [128];
  logic [15:0] exp_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    exp_cnt = '0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    bus.we        = 1'b1;
    bus.address_w = a;
    bus.data_w    = d;
    model[a]      = d;
    tick();
    bus.we        = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [6:0] a);
    bus.address_r = a;
    #1;
    exp_q.push_back(32'(model[a]));
    sb_check(tag, 32'(bus.data_r));
  endtask

  // Runs one swap on the main DUT; same_we writes same_d to entry a in the start
  // cycle, poke drives a write and a second start in cycle E+2.
  task automatic run_swap(input string tag, input logic [6:0] a, input logic [6:0] b,
                          input bit same_we, input logic [7:0] same_d, input bit poke);
    logic [7:0] t;
    int         nbusy;
    bus.swap_start  = 1'b1;
    bus.swap_addr_a = a;
    bus.swap_addr_b = b;
    bus.address_r   = a;
    if (same_we) begin
      bus.we        = 1'b1;
      bus.address_w = a;
      bus.data_w    = same_d;
      model[a]      = same_d;
    end
    t        = model[a];
    model[a] = model[b];
    model[b] = t;
    exp_cnt  = exp_cnt + 16'd1;
    exp_q.push_back(32'(model[b]));
    exp_q.push_back(32'(model[a]));
    exp_q.push_back(32'(exp_cnt));
    tick();
    bus.swap_start = 1'b0;
    bus.we         = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.swap_done) break;
      if (bus.swap_busy) nbusy++;
      if (i == 2) chk({tag, "_mid_a"}, 32'(bus.data_r), 32'(model[a]));
      if (poke && i == 1) begin
        bus.we          = 1'b1;
        bus.address_w   = 7'd20;
        bus.data_w      = 8'h55;
        bus.swap_start  = 1'b1;
        bus.swap_addr_a = 7'd20;
        bus.swap_addr_b = 7'd21;
      end
      tick();
      if (poke && i == 1) begin
        bus.we         = 1'b0;
        bus.swap_start = 1'b0;
        chk({tag, "_wr_rej"}, 32'(bus.wr_rejected), 32'd1);
      end
    end
    chk({tag, "_done"}, 32'(bus.swap_done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd3);
    chk({tag, "_busy_off"}, 32'(bus.swap_busy), 32'd0);
    chk({tag, "_rej_off"}, 32'(bus.wr_rejected), 32'd0);
    bus.address_r = b;
    #1;
    sb_check({tag, "_b"}, 32'(bus.data_r));
    bus.address_r = a;
    #1;
    sb_check({tag, "_a"}, 32'(bus.data_r));
    sb_check({tag, "_count"}, 32'(bus.swap_count));
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.swap_done), 32'd0);
    chk({tag, "_idle"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.we = 1'b0;  bus.address_w = '0; bus.data_w = '0; bus.address_r = '0;
    bus.swap_start = 1'b0; bus.swap_addr_a = '0; bus.swap_addr_b = '0;
    bus2.we = 1'b0; bus2.address_w = '0; bus2.data_w = '0; bus2.address_r = '0;
    bus2.swap_start = 1'b0; bus2.swap_addr_a = 7'd1; bus2.swap_addr_b = 7'd2;
    clear_model();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy", 32'(bus.swap_busy), 32'd0);
    chk("rst_done", 32'(bus.swap_done), 32'd0);
    chk("rst_rej", 32'(bus.wr_rejected), 32'd0);
    chk("rst_count", 32'(bus.swap_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Reset clears a written entry
    do_write(7'd3, 8'hAA);
    read_check("t1_pre", 7'd3);
    rst_n = 1'b0;
    #1;
    clear_model();
    read_check("t1_mem3", 7'd3);
    chk("t1_busy", 32'(bus.swap_busy), 32'd0);
    chk("t1_done", 32'(bus.swap_done), 32'd0);
    chk("t1_count", 32'(bus.swap_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic swap
    do_write(7'd5, 8'h11);
    do_write(7'd9, 8'h22);
    run_swap("t2", 7'd5, 7'd9, 1'b0, 8'h00, 1'b0);

    // Write and start in the same cycle
    run_swap("t3", 7'd5, 7'd9, 1'b1, 8'h33, 1'b0);
    read_check("t3_mem9", 7'd9);

    // Write and start while busy are both dropped
    do_write(7'd10, 8'hA1);
    do_write(7'd11, 8'hB2);
    run_swap("t4", 7'd10, 7'd11, 1'b0, 8'h00, 1'b1);
    read_check("t4_mem20", 7'd20);
    read_check("t4_mem21", 7'd21);

    // Degenerate swap a == b
    do_write(7'd7, 8'h77);
    run_swap("t5", 7'd7, 7'd7, 1'b0, 8'h00, 1'b0);
    read_check("t5_mem7", 7'd7);

    // Reset while in WR_A
    bus.swap_start  = 1'b1;
    bus.swap_addr_a = 7'd5;
    bus.swap_addr_b = 7'd9;
    tick();
    bus.swap_start = 1'b0;
    tick();
    chk("t6_in_wr_a", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("t6_busy", 32'(bus.swap_busy), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'd0);
    chk("t6_count", 32'(bus.swap_count), 32'd0);
    read_check("t6_mem5", 7'd5);
    read_check("t6_mem9", 7'd9);
    read_check("t6_mem7", 7'd7);
    tick();
    rst_n = 1'b1;
    tick();

    // Counter wrap on the narrow-counter instance
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'((k + 1) % 4));
      bus2.swap_start = 1'b1;
      tick();
      bus2.swap_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (bus2.swap_done) break;
        tick();
      end
      chk("t6_wrap_done", 32'(bus2.swap_done), 32'd1);
      sb_check("t6_wrap_count", 32'(bus2.swap_count));
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
